pulse_stretch_gen: RTL and testbench
====================================

// Module: pulse_stretch_gen
// PURPOSE
//  Inverse of the edge-capture function: turns a single-cycle strobe into a timed level pulse of
//  programmable width. Drives enables/strobes to blocks that need a held level (start lines, LED
//  or IRQ hold, DMA kick). Retrigger policy and output polarity are set at elaboration.
// PARAMETERS
//  OUT_POLARITY  0   0 = pulse_o active-high, 1 = pulse_o active-low
//  RETRIGGER     0   0 = triggers while ACTIVE dropped, 1 = trigger while ACTIVE reloads the count
//  CNT_W         8   width of width_i and internal down-counter (max pulse 2^CNT_W-1 cycles)
// PORTS
//  clk        in   1      single clock; all logic on rising edge
//  rst        in   1      asynchronous, active-high reset
//  trig_i     in   1      trigger strobe, sampled every rising edge (level-sampled, not edge)
//  width_i    in   CNT_W  pulse width in cycles, captured in the cycle trig_i is accepted
//  pulse_o    out  1      stretched pulse, registered, polarity per OUT_POLARITY
//  busy_o     out  1      1 while in ACTIVE (internal, always active-high)
//  done_o     out  1      1-cycle strobe: first inactive cycle after a completed pulse
//  dropped_o  out  1      1-cycle strobe: trigger ignored (RETRIGGER=0 only)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-pulse): state IDLE, cnt=0, pulse_o=inactive level
//    (0 if OUT_POLARITY=0, 1 if 1), busy_o=0, done_o=0, dropped_o=0. No done_o for aborted pulse.
//  - States: IDLE, ACTIVE. All outputs registered; no combinational path input->output.
//  - IDLE, trig_i=1, width_i=W>0: load cnt=W, go ACTIVE. pulse_o active from next cycle for
//    exactly W consecutive cycles (latency 1 cycle trigger->pulse).
//  - IDLE, trig_i=1, width_i=0: stay IDLE, no pulse; done_o=1 next cycle (zero-length pulse done).
//  - ACTIVE: cnt decrements each cycle; pulse_o active while ACTIVE. Cycle with cnt==1 is last.
//  - Last cycle (cnt==1), trig_i=0: next cycle IDLE, pulse_o inactive, busy_o=0, done_o=1.
//  - Last cycle (cnt==1), trig_i=1, W>0, either RETRIGGER: back-to-back accept; reload cnt=W,
//    pulse_o stays active with no gap, no done_o, no dropped_o. W=0 here -> normal finish + done_o.
//  - ACTIVE, cnt>1, trig_i=1, RETRIGGER=0: ignored, dropped_o=1 next cycle, count unaffected.
//  - ACTIVE, cnt>1, trig_i=1, RETRIGGER=1: reload cnt=W (width_i now); pulse ends W cycles after
//    the reload edge. width_i=0 in this case: treated as stop, finish next cycle with done_o=1.
//  - trig_i held high N cycles: each cycle is a trigger per rules above (RETRIGGER=1 extends
//    pulse until W cycles after trig_i falls; RETRIGGER=0 gives dropped_o each non-final cycle).
//  - width_i ignored except in the accept/reload cycle; changes mid-pulse have no effect.
//  - done_o and dropped_o never both 1 in one cycle; done_o only in the cycle busy_o falls.
// STRUCTURE
//  - Shared header pulse_defs.vh: POL_ACTIVE_HIGH/POL_ACTIVE_LOW constants, used also by other
//    strobe/level blocks. State encoding local to this module.
//  - One sub-module: pulse_width_counter (loadable CNT_W down-counter, load/dec/is_last outputs).
//  - Top holds FSM, polarity register and strobe registers.
// TESTING
//  1 rst pulse then trig_i 1 cycle, width_i=5 -> pulse_o active cycles +1..+5, done_o at +6 only.
//  2 OUT_POLARITY=1: idle/reset pulse_o=1; trig W=3 -> pulse_o=0 for 3 cycles, then 1 + done_o.
//  3 RETRIGGER=0, W=8, 2nd trig at cycle +3 -> dropped_o at +4, pulse still 8 cycles total.
//    RETRIGGER=1 same stimulus with W=8 -> pulse ends 8 cycles after reload (11 total), 1 done_o.
//  4 W=4, trig again in last active cycle with W=2 -> 6 contiguous active cycles, single done_o.
//  5 width_i=0 trigger from IDLE -> no pulse_o activity, busy_o=0, done_o=1 next cycle.
//  6 rst asserted mid-pulse (cycle 3 of 10) -> pulse_o inactive immediately (async), no done_o;
//    new trigger after release W=2 -> clean 2-cycle pulse.

Source files
------------

// File: rtl/pulse_stretch_gen_pkg.sv
// Shared constants for strobe/level blocks: output polarity codes and a level helper.
// Pure definitions; no latency or flow control of its own.
package pulse_stretch_gen_pkg;

   localparam int POL_ACTIVE_HIGH = 0;
   localparam int POL_ACTIVE_LOW  = 1;

   // Map an internal active-high condition onto the physical pin level.
   function automatic logic pulse_level(input int pol, input logic active);
      return (pol == POL_ACTIVE_LOW) ? ~active : active;
   endfunction

endpackage

// File: rtl/pulse_stretch_gen_if.sv
// Trigger/width request and pulse/status outputs of the pulse stretcher.
// Master drives the trigger side; slave (the stretcher) drives the status side.
interface pulse_stretch_gen_if #(
   parameter int CNT_W = 8
);
   logic             trig_i;
   logic [CNT_W-1:0] width_i;
   logic             pulse_o;
   logic             busy_o;
   logic             done_o;
   logic             dropped_o;

   modport master (
      output trig_i, width_i,
      input  pulse_o, busy_o, done_o, dropped_o
   );

   modport slave (
      input  trig_i, width_i,
      output pulse_o, busy_o, done_o, dropped_o
   );
endinterface

// File: rtl/pulse_width_counter.sv
// Loadable down-counter timing the active pulse; is_last flags the final active cycle.
// Load takes priority over decrement; saturates at zero, never stalls.
module pulse_width_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic             is_last
);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_ONE;
      end
   end

   assign is_last = (cnt == CNT_ONE);

endmodule

// File: rtl/pulse_stretch_gen.sv
// Stretches a 1-cycle trigger into a W-cycle level pulse; 1 cycle trig->pulse, all outputs registered.
// No backpressure: triggers are accepted, reloaded or reported via dropped_o every cycle.
module pulse_stretch_gen
   import pulse_stretch_gen_pkg::*;
#(
   parameter int OUT_POLARITY = POL_ACTIVE_HIGH,
   parameter int RETRIGGER    = 0,
   parameter int CNT_W        = 8
) (
   input  logic                clk,
   input  logic                rst,
   pulse_stretch_gen_if.slave  bus
);
   typedef enum logic {
      S_IDLE,
      S_ACTIVE
   } state_t;

   state_t state;
   logic   pulse_q;
   logic   busy_q;
   logic   done_q;
   logic   dropped_q;
   logic   is_last;
   logic   width_nz;
   logic   trig_take;
   logic   cnt_load;
   logic   cnt_dec;

   assign width_nz  = |bus.width_i;
   // A trigger is taken from IDLE, in the final active cycle, or anywhere when retriggerable.
   assign trig_take = bus.trig_i && ((state == S_IDLE) || is_last || (RETRIGGER != 0));
   assign cnt_load  = trig_take;
   assign cnt_dec   = (state == S_ACTIVE) && !trig_take;

   pulse_width_counter #(
      .CNT_W (CNT_W)
   ) u_width_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (bus.width_i),
      .is_last  (is_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         pulse_q   <= pulse_level(OUT_POLARITY, 1'b0);
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         dropped_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.trig_i) begin
                  if (width_nz) begin
                     state   <= S_ACTIVE;
                     pulse_q <= pulse_level(OUT_POLARITY, 1'b1);
                     busy_q  <= 1'b1;
                  end else begin
                     done_q  <= 1'b1;
                  end
               end
            end
            S_ACTIVE: begin
               // A zero-width accept/reload acts as a stop request.
               if ((trig_take && !width_nz) || (!trig_take && is_last)) begin
                  state   <= S_IDLE;
                  pulse_q <= pulse_level(OUT_POLARITY, 1'b0);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else if (bus.trig_i && !trig_take) begin
                  dropped_q <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.pulse_o   = pulse_q;
   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;
   assign bus.dropped_o = dropped_q;

endmodule

// File: tb/tb_pulse_stretch_gen.sv
// Bench: two instances (active-high/no-retrigger and active-low/retrigger) share one stimulus
// stream; each row lists the expected active/done/dropped state after the sampling edge.
module tb_pulse_stretch_gen;

   typedef struct {
      logic       trig;
      logic [7:0] width;
      logic       a0, d0, x0;
      logic       a1, d1, x1;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       trig;
   logic [7:0] width;
   int         checks;
   int         errors;
   vec_t       vecs[$];

   pulse_stretch_gen_if #(.CNT_W(8)) if0 ();
   pulse_stretch_gen_if #(.CNT_W(8)) if1 ();

   assign if0.trig_i  = trig;
   assign if0.width_i = width;
   assign if1.trig_i  = trig;
   assign if1.width_i = width;

   pulse_stretch_gen #(.OUT_POLARITY(0), .RETRIGGER(0), .CNT_W(8)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0.slave)
   );

   pulse_stretch_gen #(.OUT_POLARITY(1), .RETRIGGER(1), .CNT_W(8)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic t, input logic [7:0] w,
                               input logic a0, input logic d0, input logic x0,
                               input logic a1, input logic d1, input logic x1);
      vec_t v;
      v.trig = t;  v.width = w;
      v.a0 = a0;   v.d0 = d0;  v.x0 = x0;
      v.a1 = a1;   v.d1 = d1;  v.x1 = x1;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %b expected %b", nm, idx, act, exp);
      end
   endtask

   // u1 is active-low, so its pin is the complement of the active flag.
   task automatic chk_outputs(input int idx, input vec_t v);
      chk("u0_pulse",   idx, if0.pulse_o,   v.a0);
      chk("u0_busy",    idx, if0.busy_o,    v.a0);
      chk("u0_done",    idx, if0.done_o,    v.d0);
      chk("u0_dropped", idx, if0.dropped_o, v.x0);
      chk("u1_pulse",   idx, if1.pulse_o,   ~v.a1);
      chk("u1_busy",    idx, if1.busy_o,    v.a1);
      chk("u1_done",    idx, if1.done_o,    v.d1);
      chk("u1_dropped", idx, if1.dropped_o, v.x1);
   endtask

   task automatic run_row(input int idx, input vec_t v);
      trig  = v.trig;
      width = v.width;
      @(posedge clk);
      #1;
      chk_outputs(idx, v);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      trig   = 1'b0;
      width  = 8'd0;

      // single trigger W=5 (u1 also shows the active-low level)
      vecs.push_back(mk(1, 5, 1,0,0, 1,0,0));
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 7, 1,0,0, 1,0,0));
      vecs.push_back(mk(0, 7, 0,1,0, 0,1,0));
      vecs.push_back(mk(0, 0, 0,0,0, 0,0,0));
      // W=8, second trigger three cycles in: dropped on u0, reload on u1
      vecs.push_back(mk(1, 8, 1,0,0, 1,0,0));
      for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 8, 1,0,0, 1,0,0));
      vecs.push_back(mk(1, 8, 1,0,1, 1,0,0));
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 3, 1,0,0, 1,0,0));
      vecs.push_back(mk(0, 3, 0,1,0, 1,0,0));
      for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 3, 0,0,0, 1,0,0));
      vecs.push_back(mk(0, 3, 0,0,0, 0,1,0));
      vecs.push_back(mk(0, 0, 0,0,0, 0,0,0));
      // W=4 then back-to-back W=2 in the last active cycle
      vecs.push_back(mk(1, 4, 1,0,0, 1,0,0));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 9, 1,0,0, 1,0,0));
      vecs.push_back(mk(1, 2, 1,0,0, 1,0,0));
      vecs.push_back(mk(0, 9, 1,0,0, 1,0,0));
      vecs.push_back(mk(0, 9, 0,1,0, 0,1,0));
      vecs.push_back(mk(0, 0, 0,0,0, 0,0,0));
      // zero-width trigger from idle
      vecs.push_back(mk(1, 0, 0,1,0, 0,1,0));
      vecs.push_back(mk(0, 0, 0,0,0, 0,0,0));
      // zero-width trigger mid-pulse: dropped on u0, stop on u1
      vecs.push_back(mk(1, 5, 1,0,0, 1,0,0));
      vecs.push_back(mk(0, 5, 1,0,0, 1,0,0));
      vecs.push_back(mk(1, 0, 1,0,1, 0,1,0));
      for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 5, 1,0,0, 0,0,0));
      vecs.push_back(mk(0, 5, 0,1,0, 0,0,0));
      vecs.push_back(mk(0, 0, 0,0,0, 0,0,0));
      // zero-width trigger in the last cycle: normal finish
      vecs.push_back(mk(1, 2, 1,0,0, 1,0,0));
      vecs.push_back(mk(0, 2, 1,0,0, 1,0,0));
      vecs.push_back(mk(1, 0, 0,1,0, 0,1,0));
      vecs.push_back(mk(0, 0, 0,0,0, 0,0,0));
      // trigger held three cycles, W=3
      vecs.push_back(mk(1, 3, 1,0,0, 1,0,0));
      for (int i = 0; i < 2; i++) vecs.push_back(mk(1, 3, 1,0,1, 1,0,0));
      vecs.push_back(mk(0, 3, 0,1,0, 1,0,0));
      vecs.push_back(mk(0, 3, 0,0,0, 1,0,0));
      vecs.push_back(mk(0, 3, 0,0,0, 0,1,0));
      vecs.push_back(mk(0, 0, 0,0,0, 0,0,0));

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk_outputs(-1, mk(0, 0, 0,0,0, 0,0,0));
      rst = 1'b0;

      foreach (vecs[i]) run_row(i, vecs[i]);

      // async reset at cycle 3 of a 10-cycle pulse, then a clean W=2 pulse
      run_row(100, mk(1, 10, 1,0,0, 1,0,0));
      run_row(101, mk(0, 10, 1,0,0, 1,0,0));
      run_row(102, mk(0, 10, 1,0,0, 1,0,0));
      #2;
      rst = 1'b1;
      #1;
      chk_outputs(103, mk(0, 0, 0,0,0, 0,0,0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_outputs(104, mk(0, 0, 0,0,0, 0,0,0));
      run_row(105, mk(0, 0, 0,0,0, 0,0,0));
      run_row(106, mk(1, 2, 1,0,0, 1,0,0));
      run_row(107, mk(0, 2, 1,0,0, 1,0,0));
      run_row(108, mk(0, 2, 0,1,0, 0,1,0));
      run_row(109, mk(0, 0, 0,0,0, 0,0,0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
